// File: rtl/rv32i_types.sv
// Shared types for the pipeline control path: stall FSM states and the
// control word that a flushed stage register loads in place of its input.
package rv32i_types;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        REPLAY = 2'd2
    } pipe_state_t;

    localparam int CTRL_W = 32;

    // All-zero control word: no register write, no memory access, no branch.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not produced yet. x0 never creates a dependency.
module hazard_detect
    import rv32i_types::*;
(
    input  logic       ex_load,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    // Dependency exists when a load targets a non-zero register read in ID.
    always_comb begin
        load_use = ex_load && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller. Freezes every stage register while a cache
// response is outstanding, resolves branches and load-use hazards otherwise,
// and replays a fetch that was captured into the instruction buffer while the
// data side was still waiting.
module pipeline_controller
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_read,
    input  logic        icache_resp,
    input  logic        dcache_req,
    input  logic        dcache_resp,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        br_taken,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        pc_redirect,
    output logic        ibuf_load,
    output logic        ibuf_sel,
    output logic [31:0] stall_cycles
);

    pipe_state_t state, next_state;
    logic        i_done, d_done;
    logic        i_done_next, d_done_next;
    logic        load_use;
    logic        i_sat, d_sat, miss, d_miss, run_act;
    logic [31:0] cnt_q;

    hazard_detect u_hazard (
        .ex_load  (ex_load),
        .ex_rd    (ex_rd),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .load_use (load_use)
    );

    // Next-state and stage-control decode; RUN-style priority is applied last
    // whenever the current cycle is allowed to advance the pipeline normally.
    always_comb begin
        next_state  = state;
        i_done_next = i_done;
        d_done_next = d_done;
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        pc_redirect = 1'b0;
        ibuf_load   = 1'b0;
        ibuf_sel    = 1'b0;
        run_act     = 1'b0;

        // A side with no active request counts as already satisfied.
        i_sat  = i_done || icache_resp || !icache_read;
        d_sat  = d_done || dcache_resp || !dcache_req;
        miss   = (icache_read && !icache_resp) || (dcache_req && !dcache_resp);
        d_miss = dcache_req && !dcache_resp;

        case (state)
            RUN: begin
                if (miss) begin
                    next_state = STALL;
                end else begin
                    run_act = 1'b1;
                end
            end
            STALL: begin
                if (i_sat && d_sat) begin
                    i_done_next = 1'b0;
                    d_done_next = 1'b0;
                    // A fetch that landed earlier sits in the buffer, so the
                    // pipeline stays frozen one more cycle and releases it next.
                    if (i_done) begin
                        next_state = REPLAY;
                    end else begin
                        next_state = RUN;
                        run_act    = 1'b1;
                    end
                end else begin
                    if (icache_resp && !i_done) begin
                        i_done_next = 1'b1;
                        ibuf_load   = 1'b1;
                    end
                    if (dcache_resp) begin
                        d_done_next = 1'b1;
                    end
                end
            end
            REPLAY: begin
                // The fetch is served from the buffer, so only the data side
                // can stall here; the buffered fetch then still counts as done.
                if (d_miss) begin
                    next_state  = STALL;
                    i_done_next = 1'b1;
                    d_done_next = 1'b0;
                end else begin
                    next_state  = RUN;
                    load_pc     = 1'b1;
                    load_if_id  = 1'b1;
                    load_id_ex  = 1'b1;
                    load_ex_mem = 1'b1;
                    load_mem_wb = 1'b1;
                    ibuf_sel    = 1'b1;
                    if (br_taken) begin
                        pc_redirect = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase

        if (run_act) begin
            if (br_taken) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                pc_redirect = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_id_ex = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
        end

        if (rst) begin
            load_pc     = 1'b0;
            load_if_id  = 1'b0;
            load_id_ex  = 1'b0;
            load_ex_mem = 1'b0;
            load_mem_wb = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
            pc_redirect = 1'b0;
            ibuf_load   = 1'b0;
            ibuf_sel    = 1'b0;
        end
    end

    // FSM state and sticky response flags; reset abandons any pending replay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            state  <= next_state;
            i_done <= i_done_next;
            d_done <= d_done_next;
        end
    end

    // Frozen-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (!load_pc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller. The driver applies one vector per
// cycle and queues its hand-computed response; the monitor pops and compares
// on the falling edge.
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_read = 1'b0, icache_resp = 1'b0;
    logic        dcache_req = 1'b0, dcache_resp = 1'b0;
    logic        ex_load = 1'b0, br_taken = 1'b0;
    logic [4:0]  ex_rd = 5'd0, id_rs1 = 5'd0, id_rs2 = 5'd0;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, pc_redirect, ibuf_load, ibuf_sel;
    logic [31:0] stall_cycles;

    // {load_pc,load_if_id,load_id_ex,load_ex_mem,load_mem_wb,
    //  flush_if_id,flush_id_ex,pc_redirect,ibuf_load,ibuf_sel}
    localparam logic [9:0] FROZEN  = 10'b00000_00_000;
    localparam logic [9:0] NORMAL  = 10'b11111_00_000;
    localparam logic [9:0] LOADUSE = 10'b00111_01_000;
    localparam logic [9:0] BRANCH  = 10'b11111_11_100;
    localparam logic [9:0] IBUFCAP = 10'b00000_00_010;
    localparam logic [9:0] REPLAYO = 10'b11111_00_001;

    // {icache_read,icache_resp,dcache_req,dcache_resp,br_taken}
    localparam logic [4:0] IDLE   = 5'b00000;
    localparam logic [4:0] BR     = 5'b00001;
    localparam logic [4:0] DMISS  = 5'b00100;
    localparam logic [4:0] DRESP  = 5'b00110;
    localparam logic [4:0] DMISSB = 5'b00101;
    localparam logic [4:0] DRESPB = 5'b00111;
    localparam logic [4:0] IDMISS = 5'b10100;
    localparam logic [4:0] ICAP   = 5'b11100;
    localparam logic [4:0] IDEXIT = 5'b10110;

    typedef struct {
        string       name;
        logic [9:0]  outs;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    pipeline_controller dut (
        .clk          (clk),
        .rst          (rst),
        .icache_read  (icache_read),
        .icache_resp  (icache_resp),
        .dcache_req   (dcache_req),
        .dcache_resp  (dcache_resp),
        .ex_load      (ex_load),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .br_taken     (br_taken),
        .load_pc      (load_pc),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .pc_redirect  (pc_redirect),
        .ibuf_load    (ibuf_load),
        .ibuf_sel     (ibuf_sel),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Drive one vector just after the rising edge and queue its expectation.
    task automatic applyStimulus(input string name, input logic r, input logic [4:0] ctl,
                                 input logic exl, input logic [4:0] exrd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [9:0] outs, input bit chk, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        icache_read = ctl[4];
        icache_resp = ctl[3];
        dcache_req  = ctl[2];
        dcache_resp = ctl[1];
        br_taken    = ctl[0];
        ex_load     = exl;
        ex_rd       = exrd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        e.name    = name;
        e.outs    = outs;
        e.chk_cnt = chk;
        e.cnt     = cnt;
        sb.push_back(e);
    endtask

    // Compare the live DUT outputs against one queued expectation.
    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               flush_if_id, flush_id_ex, pc_redirect, ibuf_load, ibuf_sel};
        vectors++;
        if (act !== e.outs) begin
            miscompares++;
            $display("[TB] FAIL %s: controls got %b expected %b", e.name, act, e.outs);
        end
        if (e.chk_cnt && (stall_cycles !== e.cnt)) begin
            miscompares++;
            $display("[TB] FAIL %s: stall_cycles got %h expected %h", e.name, stall_cycles, e.cnt);
        end
    endtask

    // Monitor: one comparison per falling edge whenever an expectation waits.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    initial begin
        // Reset state and basic hazard/branch decode.
        applyStimulus("reset",        1'b1, IDLE, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        applyStimulus("normal",       1'b0, IDLE, 1'b0, 5'd0, 5'd0, 5'd0, NORMAL,  1'b1, 32'd0);
        applyStimulus("loaduse_rs2",  1'b0, IDLE, 1'b1, 5'd5, 5'd3, 5'd5, LOADUSE, 1'b1, 32'd0);
        applyStimulus("loaduse_rs1",  1'b0, IDLE, 1'b1, 5'd7, 5'd7, 5'd2, LOADUSE, 1'b1, 32'd1);
        applyStimulus("loaduse_x0",   1'b0, IDLE, 1'b1, 5'd0, 5'd0, 5'd0, NORMAL,  1'b1, 32'd2);
        applyStimulus("noload_match", 1'b0, IDLE, 1'b0, 5'd5, 5'd5, 5'd5, NORMAL,  1'b1, 32'd2);
        applyStimulus("br_loaduse",   1'b0, BR,   1'b1, 5'd5, 5'd1, 5'd5, BRANCH,  1'b1, 32'd2);
        applyStimulus("br_only",      1'b0, BR,   1'b0, 5'd0, 5'd0, 5'd0, BRANCH,  1'b1, 32'd2);

        // Four-cycle data miss, then exit with a branch held by EX.
        applyStimulus("rst_d",        1'b1, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("dmiss",    1'b0, DMISS,  1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'(i));
        end
        applyStimulus("dmiss_exit",   1'b0, DRESP,  1'b0, 5'd0, 5'd0, 5'd0, NORMAL, 1'b1, 32'd4);
        applyStimulus("after_exit",   1'b0, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, NORMAL, 1'b1, 32'd4);
        applyStimulus("dmiss_br",     1'b0, DMISSB, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'd4);
        applyStimulus("dexit_br",     1'b0, DRESPB, 1'b1, 5'd4, 5'd4, 5'd0, BRANCH, 1'b1, 32'd5);

        // Fetch lands early, data late: capture, frozen exit, then replay.
        applyStimulus("rst_i",        1'b1, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        applyStimulus("id_miss0",     1'b0, IDMISS, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        applyStimulus("id_miss1",     1'b0, IDMISS, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd1);
        applyStimulus("icap",         1'b0, ICAP,   1'b0, 5'd0, 5'd0, 5'd0, IBUFCAP, 1'b1, 32'd2);
        applyStimulus("dwait3",       1'b0, IDMISS, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd3);
        applyStimulus("dwait4",       1'b0, IDMISS, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd4);
        applyStimulus("exit_replay",  1'b0, IDEXIT, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd5);
        applyStimulus("replay",       1'b0, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, REPLAYO, 1'b1, 32'd6);
        applyStimulus("post_replay",  1'b0, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, NORMAL,  1'b1, 32'd6);

        // Asynchronous reset pulse mid-stall with a captured fetch pending.
        applyStimulus("rst_a",        1'b1, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        applyStimulus("a_miss",       1'b0, IDMISS, 1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        applyStimulus("a_icap",       1'b0, ICAP,   1'b0, 5'd0, 5'd0, 5'd0, IBUFCAP, 1'b1, 32'd1);
        applyStimulus("a_rst_pulse",  1'b1, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, FROZEN,  1'b1, 32'd0);
        #6;
        rst = 1'b0;
        applyStimulus("a_post_rst",   1'b0, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, NORMAL,  1'b1, 32'd0);

        // Counter preset just below all-ones, then stall past saturation.
        applyStimulus("rst_s",        1'b1, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'd0);
        applyStimulus("s_preset",     1'b0, IDLE,   1'b0, 5'd0, 5'd0, 5'd0, NORMAL, 1'b0, 32'd0);
        force dut.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.cnt_q;
        applyStimulus("s_miss1",      1'b0, DMISS,  1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'hFFFF_FFFD);
        applyStimulus("s_miss2",      1'b0, DMISS,  1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'hFFFF_FFFE);
        applyStimulus("s_miss3",      1'b0, DMISS,  1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'hFFFF_FFFF);
        applyStimulus("s_miss4",      1'b0, DMISS,  1'b0, 5'd0, 5'd0, 5'd0, FROZEN, 1'b1, 32'hFFFF_FFFF);
        applyStimulus("s_exit",       1'b0, DRESP,  1'b0, 5'd0, 5'd0, 5'd0, NORMAL, 1'b1, 32'hFFFF_FFFF);

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset), in that order; one clock; reset is asynchronous and active-high.
REQ-002 SHALL have icache_read (input, 1): fetch request outstanding this cycle; icache_resp (input, 1): fetch data valid.
REQ-003 SHALL have dcache_req (input, 1): EX/MEM control word has dcache_read or dcache_write set; dcache_resp (input, 1): data access complete.
REQ-004 SHALL have ex_load (input, 1): ID/EX control word dcache_read; ex_rd (input, 5); id_rs1, id_rs2 (input, 5 each): IF/ID source registers.
REQ-005 SHALL have br_taken (input, 1): EX-stage redirect (br_en or jump) resolved this cycle.
REQ-006 SHALL have load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb (output, 1 each): stage-register load enables.
REQ-007 SHALL have flush_if_id, flush_id_ex (output, 1 each): the stage loads the bubble word (all-zero control word) instead of input_word.
REQ-008 SHALL have pc_redirect (output, 1): PC mux selects branch target; ibuf_load (output, 1): capture icache data; ibuf_sel (output, 1): IF/ID takes captured data.
REQ-009 SHALL have stall_cycles (output, 32): count of frozen cycles.

Function
REQ-010 SHALL implement FSM states RUN, STALL, REPLAY.
- RUN: no outstanding miss.
- STALL: at least one cache response outstanding.
- REPLAY: a single cycle that releases the captured fetch.
REQ-011 RUN->STALL SHALL occur when (icache_read & !icache_resp) | (dcache_req & !dcache_resp).
REQ-012 In STALL, all five load enables SHALL be 0 and both flushes 0.
REQ-013 Sticky flags i_done and d_done SHALL be set on the respective resp in STALL and cleared on STALL exit; a flag whose request is not active SHALL be treated as done.
REQ-014 When icache_resp arrives in STALL while d_done=0, ibuf_load=1 for that cycle, and the state on exit SHALL be REPLAY instead of RUN.
REQ-015 STALL->RUN (or REPLAY) SHALL occur in the cycle both flags are satisfied, including the resp arriving this cycle; that cycle behaves as RUN, except in the REPLAY case.
REQ-016 REPLAY SHALL assert ibuf_sel=1 and all loads=1 unless a new miss occurs, then SHALL return to RUN.
REQ-017 Load-use hazard SHALL be ex_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2). In RUN it SHALL force load_pc=0, load_if_id=0, flush_id_ex=1, and ex_mem/mem_wb loads=1.
REQ-018 br_taken in RUN without a miss SHALL force pc_redirect=1, flush_if_id=1, flush_id_ex=1, and all loads=1; a branch SHALL override the load-use hazard.
REQ-019 Priority SHALL be miss/STALL > br_taken > load-use > normal (all loads=1, no flush).
REQ-020 During STALL, br_taken is held stable by the frozen EX stage and SHALL be acted on in the exit cycle.
REQ-021 stall_cycles SHALL increment once per cycle in which load_pc=0 and SHALL saturate at 32'hFFFF_FFFF.
REQ-022 All outputs other than stall_cycles SHALL be combinational from state, flags, and inputs, with no input-to-output path through the counter.

Reset
REQ-023 rst=1 SHALL asynchronously force state=RUN, i_done=d_done=0, and stall_cycles=0.
REQ-024 A reset asserted mid-STALL SHALL abandon any pending ibuf replay; the first post-reset cycle SHALL evaluate as RUN.
REQ-025 While rst=1, all load enables SHALL be 0 and all flush, redirect, and ibuf outputs 0.

Structure
REQ-026 The FSM state enum (pipe_state_t) and the bubble-control constant SHALL live in rv32i_types.
REQ-027 One sub-module, hazard_detect, SHALL compute the combinational load-use condition (REQ-017).
REQ-028 Target size SHALL be 150-250 lines of RTL.

Verification
REQ-029 Load-use: ex_load=1, ex_rd=5, id_rs2=5, no miss -> load_pc=0, load_if_id=0, flush_id_ex=1, load_ex_mem=1; with ex_rd=0 -> no stall.
REQ-030 Branch plus load-use in the same cycle: br_taken=1 -> pc_redirect=1, both flushes=1, all loads=1.
REQ-031 Dcache miss for 4 cycles -> all loads=0 for 4 cycles; dcache_resp on cycle 4 -> loads=1 that cycle; stall_cycles=4.
REQ-032 Icache resp at cycle 2 and dcache resp at cycle 5 -> ibuf_load=1 at cycle 2, STALL exit at cycle 5, REPLAY with ibuf_sel=1 at cycle 6.
REQ-033 Asynchronous rst pulse mid-STALL, between clock edges -> outputs immediately 0 and state RUN; stall_cycles=0 after release.
REQ-034 Counter preset near saturation with 3 more stall cycles -> stall_cycles=32'hFFFF_FFFF, no wrap.
